j_serial_wgt_accum: RTL and testbench
=====================================

// Module: j_serial_wgt_accum
// PURPOSE
//  Downstream consumer of the weight shifter's bit-serial stream. Reassembles SHIFT_WIDTH-bit chunks
//  (LSB chunk first) into 8-bit weights, sign-extends and accumulates them over a frame of frame_len
//  words, then presents the sum on a one-entry valid/ready output. Flags protocol faults as sticky errors.
// PARAMETERS
//  SHIFT_WIDTH  8   chunk width in bits; legal values 1, 2, 4, 8; NCHUNK = 8/SHIFT_WIDTH
//  ACC_WIDTH    24  accumulator / out_data width; must be >= 8
//  LEN_W        18  frame_len width
//  SIGNED       1   1: words are two's complement; 0: words are unsigned, zero-extended
// PORTS
//  clk            in   1            clock; all logic is on the rising edge
//  reset          in   1            synchronous reset, active-high
//  acc_start      in   1            pulse; starts a frame; samples frame_len
//  frame_len      in   LEN_W        number of words in the frame
//  acc_idle       out  1            1 when state = IDLE and chunk_cnt = 0
//  serial_output  in   SHIFT_WIDTH  chunk data from the shifter
//  serial_start   in   1            marks the first chunk of a word; valid only with serial_en
//  serial_en      in   1            chunk qualifier
//  out_data       out  ACC_WIDTH    frame sum
//  out_valid      out  1            out_data is valid
//  out_ready      in   1            consumer accepts out_data
//  err_misalign   out  1            sticky; serial_start arrived mid-word, or a chunk arrived with no start
//  err_overrun    out  1            sticky; chunk arrived while in DONE or IDLE
//  err_clr        in   1            clears both error flags
// BEHAVIOUR
//  Reset values: out_data=0, out_valid=0, err_*=0, acc=0, word_cnt=0, chunk_cnt=0, state=IDLE.
//    Reset mid-frame aborts the frame and does not produce an output.
//  FSM states: IDLE, ACCUM, DONE.
//   IDLE -> ACCUM on acc_start: acc<=0; word_cnt<=0; len<=frame_len.
//     If frame_len==0, go directly to DONE with out_data=0 and out_valid=1 on the next cycle.
//   ACCUM -> DONE on the edge that completes word number len. At that edge:
//     out_data <= acc + ext(word); out_valid <= 1.
//   DONE -> IDLE when out_valid & out_ready; out_valid drops on the same edge.
//     acc_start is ignored while in DONE.
//   acc_start while in ACCUM restarts the frame: acc, word_cnt and chunk_cnt are cleared; no error.
//  Chunk assembly (ACCUM only), for each cycle with serial_en=1:
//   - serial_start=1: chunk is stored at bits [SW-1:0]; chunk_cnt<=1.
//     If chunk_cnt!=0 beforehand, the partial word is discarded and err_misalign is set.
//   - serial_start=0 and chunk_cnt!=0: chunk is stored at bits [chunk_cnt*SW +: SW]; chunk_cnt++.
//   - serial_start=0 and chunk_cnt==0: chunk is dropped; err_misalign is set.
//   - When the chunk completes the word (chunk_cnt would reach NCHUNK):
//     word = {chunk, stored bits}; acc <= acc + ext(word); word_cnt++; chunk_cnt<=0.
//     Accumulation happens on the same edge, so out_valid is seen 1 cycle after the last chunk.
//   - When SHIFT_WIDTH==8, every chunk is a complete word; serial_start is still required.
//  serial_en in IDLE or DONE: chunk is dropped; err_overrun is set. serial_en=0 holds all state.
//  Arithmetic:
//   - ext() sign-extends when SIGNED=1 and zero-extends otherwise.
//   - acc wraps modulo 2^ACC_WIDTH; there is no saturation and no overflow flag.
//  out_data and out_valid are stable while out_valid=1 and out_ready=0.
//  err_clr has priority over a same-cycle error set; the flag reads 0 on the next cycle.
// TESTING
//  SW=8, SIGNED=1, len=3, words 5, -3 (0xFD), 100 -> out_data=102, out_valid one cycle after the 3rd chunk.
//  SW=2, len=1, chunks 0,1,3,2 (start on 1st) -> word 0xB4, out_data=-76 (0xFFFFB4 for ACC_WIDTH=24).
//  Hold out_ready=0 for 5 cycles after valid -> out_data stable, acc_idle=0;
//    out_ready=1 -> IDLE next cycle, acc_idle=1.
//  SW=4, send one chunk, then serial_start again -> err_misalign=1;
//    the new word accumulates correctly; err_clr -> 0.
//  frame_len=0 -> out_valid=1 with out_data=0 one cycle after acc_start;
//    serial_en during DONE -> err_overrun=1.
//  Reset asserted mid-frame after 2 of 4 words -> all outputs 0;
//    a fresh frame of 4 words yields only their sum.

Source files
------------

// File: rtl/j_serial_wgt_accum.sv
// Reassembles bit-serial weight chunks (LSB chunk first) into 8-bit words and accumulates
// them over a frame; the frame sum is handed off on a one-entry valid/ready output.
module j_serial_wgt_accum #(
   parameter int SHIFT_WIDTH = 8,
   parameter int ACC_WIDTH   = 24,
   parameter int LEN_W       = 18,
   parameter int SIGNED      = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   acc_start,
   input  logic [LEN_W-1:0]       frame_len,
   output logic                   acc_idle,
   input  logic [SHIFT_WIDTH-1:0] serial_output,
   input  logic                   serial_start,
   input  logic                   serial_en,
   output logic [ACC_WIDTH-1:0]   out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   err_misalign,
   output logic                   err_overrun,
   input  logic                   err_clr
);

   localparam int NCHUNK = 8 / SHIFT_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   state_t                 r_state,     w_state_nxt;
   logic [ACC_WIDTH-1:0]   r_acc,       w_acc_nxt;
   logic [LEN_W-1:0]       r_word_cnt,  w_word_cnt_nxt;
   logic [LEN_W-1:0]       r_len,       w_len_nxt;
   logic [3:0]             r_chunk_cnt, w_chunk_cnt_nxt;
   logic [7:0]             r_shreg,     w_shreg_nxt;
   logic [ACC_WIDTH-1:0]   r_out_data,  w_out_data_nxt;
   logic                   r_out_valid, w_out_valid_nxt;
   logic                   r_err_mis,   w_err_mis_nxt;
   logic                   r_err_ovr,   w_err_ovr_nxt;

   logic [3:0]             w_pos;
   logic [3:0]             w_cnt_inc;
   logic [7:0]             w_asm;
   logic [ACC_WIDTH-1:0]   w_sum;
   logic [LEN_W-1:0]       w_word_inc;
   logic                   w_start_frame;
   logic                   w_set_mis;
   logic                   w_set_ovr;

   // Widen an assembled word to the accumulator width (sign or zero fill).
   function automatic logic [ACC_WIDTH-1:0] ext_word(input logic [7:0] w);
      logic [ACC_WIDTH-1:0] r;
      r      = '0;
      r[7:0] = w;
      for (int i = 8; i < ACC_WIDTH; i++) begin
         r[i] = (SIGNED != 0) ? w[7] : 1'b0;
      end
      return r;
   endfunction

   // Accumulation wraps modulo 2^ACC_WIDTH.
   function automatic logic [ACC_WIDTH-1:0] wrap_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ACC_WIDTH-1:0] b);
      return a + b;
   endfunction

   assign w_start_frame = acc_start && (r_state != S_DONE);

   always_comb begin
      w_state_nxt     = r_state;
      w_acc_nxt       = r_acc;
      w_word_cnt_nxt  = r_word_cnt;
      w_len_nxt       = r_len;
      w_chunk_cnt_nxt = r_chunk_cnt;
      w_shreg_nxt     = r_shreg;
      w_out_data_nxt  = r_out_data;
      w_out_valid_nxt = r_out_valid;
      w_set_mis       = 1'b0;
      w_set_ovr       = 1'b0;

      // A start chunk always lands in slot 0, regardless of what was pending.
      w_pos     = serial_start ? 4'd0 : r_chunk_cnt;
      w_cnt_inc = w_pos + 4'd1;
      w_asm     = r_shreg;
      for (int k = 0; k < NCHUNK; k++) begin
         if (w_pos == 4'(k)) begin
            w_asm[k*SHIFT_WIDTH +: SHIFT_WIDTH] = serial_output;
         end
      end
      w_sum      = wrap_add(r_acc, ext_word(w_asm));
      w_word_inc = r_word_cnt + 1'b1;

      case (r_state)
         S_IDLE: begin
            if (serial_en) begin
               w_set_ovr = 1'b1;
            end
         end
         S_ACCUM: begin
            if (!acc_start && serial_en) begin
               if (serial_start || (r_chunk_cnt != 4'd0)) begin
                  if (serial_start && (r_chunk_cnt != 4'd0)) begin
                     w_set_mis = 1'b1;
                  end
                  w_shreg_nxt = w_asm;
                  if (w_cnt_inc == 4'(NCHUNK)) begin
                     w_acc_nxt       = w_sum;
                     w_word_cnt_nxt  = w_word_inc;
                     w_chunk_cnt_nxt = 4'd0;
                     if (w_word_inc == r_len) begin
                        w_state_nxt     = S_DONE;
                        w_out_data_nxt  = w_sum;
                        w_out_valid_nxt = 1'b1;
                     end
                  end else begin
                     w_chunk_cnt_nxt = w_cnt_inc;
                  end
               end else begin
                  w_set_mis = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (serial_en) begin
               w_set_ovr = 1'b1;
            end
            if (r_out_valid && out_ready) begin
               w_state_nxt     = S_IDLE;
               w_out_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Starting (or restarting) a frame overrides any chunk activity this cycle.
      if (w_start_frame) begin
         w_acc_nxt       = '0;
         w_word_cnt_nxt  = '0;
         w_chunk_cnt_nxt = 4'd0;
         w_len_nxt       = frame_len;
         if (frame_len == '0) begin
            w_state_nxt     = S_DONE;
            w_out_data_nxt  = '0;
            w_out_valid_nxt = 1'b1;
         end else begin
            w_state_nxt = S_ACCUM;
         end
      end

      w_err_mis_nxt = err_clr ? 1'b0 : (r_err_mis | w_set_mis);
      w_err_ovr_nxt = err_clr ? 1'b0 : (r_err_ovr | w_set_ovr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_word_cnt  <= '0;
         r_len       <= '0;
         r_chunk_cnt <= 4'd0;
         r_shreg     <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_err_mis   <= 1'b0;
         r_err_ovr   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_acc       <= w_acc_nxt;
         r_word_cnt  <= w_word_cnt_nxt;
         r_len       <= w_len_nxt;
         r_chunk_cnt <= w_chunk_cnt_nxt;
         r_shreg     <= w_shreg_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_err_mis   <= w_err_mis_nxt;
         r_err_ovr   <= w_err_ovr_nxt;
      end
   end

   assign acc_idle     = (r_state == S_IDLE) && (r_chunk_cnt == 4'd0);
   assign out_data     = r_out_data;
   assign out_valid    = r_out_valid;
   assign err_misalign = r_err_mis;
   assign err_overrun  = r_err_ovr;

endmodule

// File: tb/tb_j_serial_wgt_accum.sv
// Bench for j_serial_wgt_accum: three instances (chunk widths 8, 2, 4) driven with directed
// cases and random frames checked against an integer-sum reference.
module tb_j_serial_wgt_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        as_ [3];
   logic [17:0] fl  [3];
   logic        st  [3];
   logic        en  [3];
   logic        rdy [3];
   logic        clr [3];
   logic [7:0]  ser8;
   logic [1:0]  ser2;
   logic [3:0]  ser4;
   logic        idle[3];
   logic [23:0] od  [3];
   logic        ov  [3];
   logic        em  [3];
   logic        eo  [3];

   int total = 0;
   int bad   = 0;

   j_serial_wgt_accum #(.SHIFT_WIDTH(8), .ACC_WIDTH(24), .LEN_W(18), .SIGNED(1)) u_sw8 (
      .clk(clk), .reset(reset), .acc_start(as_[0]), .frame_len(fl[0]), .acc_idle(idle[0]),
      .serial_output(ser8), .serial_start(st[0]), .serial_en(en[0]), .out_data(od[0]),
      .out_valid(ov[0]), .out_ready(rdy[0]), .err_misalign(em[0]), .err_overrun(eo[0]),
      .err_clr(clr[0]));

   j_serial_wgt_accum #(.SHIFT_WIDTH(2), .ACC_WIDTH(24), .LEN_W(18), .SIGNED(1)) u_sw2 (
      .clk(clk), .reset(reset), .acc_start(as_[1]), .frame_len(fl[1]), .acc_idle(idle[1]),
      .serial_output(ser2), .serial_start(st[1]), .serial_en(en[1]), .out_data(od[1]),
      .out_valid(ov[1]), .out_ready(rdy[1]), .err_misalign(em[1]), .err_overrun(eo[1]),
      .err_clr(clr[1]));

   j_serial_wgt_accum #(.SHIFT_WIDTH(4), .ACC_WIDTH(24), .LEN_W(18), .SIGNED(1)) u_sw4 (
      .clk(clk), .reset(reset), .acc_start(as_[2]), .frame_len(fl[2]), .acc_idle(idle[2]),
      .serial_output(ser4), .serial_start(st[2]), .serial_en(en[2]), .out_data(od[2]),
      .out_valid(ov[2]), .out_ready(rdy[2]), .err_misalign(em[2]), .err_overrun(eo[2]),
      .err_clr(clr[2]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sw_of(input int d);
      return (d == 0) ? 8 : ((d == 1) ? 2 : 4);
   endfunction

   task automatic set_ser(input int d, input logic [7:0] v);
      case (d)
         0:       ser8 = v;
         1:       ser2 = v[1:0];
         default: ser4 = v[3:0];
      endcase
   endtask

   task automatic send_chunk(input int d, input logic [7:0] v, input logic s);
      set_ser(d, v);
      st[d] = s;
      en[d] = 1'b1;
      tick();
      en[d] = 1'b0;
      st[d] = 1'b0;
   endtask

   task automatic send_word(input int d, input logic [7:0] w, input int gap_pct);
      int sw;
      sw = sw_of(d);
      for (int k = 0; k < 8 / sw; k++) begin
         if ($urandom_range(0, 99) < gap_pct) tick();
         send_chunk(d, w >> (k * sw), (k == 0));
      end
   endtask

   task automatic start_frame(input int d, input int len);
      fl[d]  = 18'(len);
      as_[d] = 1'b1;
      tick();
      as_[d] = 1'b0;
   endtask

   task automatic accept(input int d, input string tag);
      rdy[d] = 1'b1;
      tick();
      rdy[d] = 1'b0;
      chk({tag, "_vld_drop"}, 32'(ov[d]), 0);
      chk({tag, "_idle"}, 32'(idle[d]), 1);
   endtask

   task automatic pulse_clr(input int d);
      clr[d] = 1'b1;
      tick();
      clr[d] = 1'b0;
   endtask

   initial begin
      logic [7:0]  w;
      logic [23:0] exp_sum;
      int          s;
      int          len;
      int          hold;

      reset = 1'b1;
      ser8 = '0; ser2 = '0; ser4 = '0;
      for (int d = 0; d < 3; d++) begin
         as_[d] = 1'b0; fl[d] = '0; st[d] = 1'b0; en[d] = 1'b0; rdy[d] = 1'b0; clr[d] = 1'b0;
      end
      tick(); tick();
      reset = 1'b0;
      tick();

      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_data%0d", d), 32'(od[d]), 0);
         chk($sformatf("rst_vld%0d", d), 32'(ov[d]), 0);
         chk($sformatf("rst_mis%0d", d), 32'(em[d]), 0);
         chk($sformatf("rst_ovr%0d", d), 32'(eo[d]), 0);
         chk($sformatf("rst_idle%0d", d), 32'(idle[d]), 1);
      end

      // SW=8: 5, -3, 100 -> 102, valid right after the third chunk
      start_frame(0, 3);
      send_word(0, 8'd5, 0);
      send_word(0, 8'hFD, 0);
      chk("sw8_vld_early", 32'(ov[0]), 0);
      send_word(0, 8'd100, 0);
      chk("sw8_vld", 32'(ov[0]), 1);
      chk("sw8_data", 32'(od[0]), 32'd102);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_data", 32'(od[0]), 32'd102);
         chk("hold_vld", 32'(ov[0]), 1);
         chk("hold_idle", 32'(idle[0]), 0);
      end
      accept(0, "sw8");

      // SW=2: chunks 0,1,3,2 -> 0xB4 -> -76
      start_frame(1, 1);
      send_chunk(1, 8'd0, 1'b1);
      send_chunk(1, 8'd1, 1'b0);
      send_chunk(1, 8'd3, 1'b0);
      chk("sw2_vld_early", 32'(ov[1]), 0);
      send_chunk(1, 8'd2, 1'b0);
      chk("sw2_vld", 32'(ov[1]), 1);
      chk("sw2_data", 32'(od[1]), 32'hFFFFB4);
      accept(1, "sw2");

      // SW=4: stray start chunk, then a fresh word
      start_frame(2, 1);
      send_chunk(2, 8'h0A, 1'b1);
      chk("mis_none_yet", 32'(em[2]), 0);
      send_word(2, 8'h37, 0);
      chk("mis_set", 32'(em[2]), 1);
      chk("mis_vld", 32'(ov[2]), 1);
      chk("mis_data", 32'(od[2]), 32'h37);
      pulse_clr(2);
      chk("mis_clr", 32'(em[2]), 0);
      accept(2, "sw4");

      // chunk without start is dropped; clear wins over a same-cycle set
      start_frame(1, 1);
      send_chunk(1, 8'd1, 1'b0);
      chk("nostart_mis", 32'(em[1]), 1);
      clr[1] = 1'b1;
      send_chunk(1, 8'd2, 1'b0);
      clr[1] = 1'b0;
      chk("clr_priority", 32'(em[1]), 0);
      send_word(1, 8'h05, 0);
      chk("nostart_data", 32'(od[1]), 32'h5);
      chk("nostart_vld", 32'(ov[1]), 1);
      accept(1, "nostart");

      // restart mid-frame discards earlier words and the pending partial word
      start_frame(1, 2);
      send_word(1, 8'h10, 0);
      send_chunk(1, 8'd3, 1'b1);
      start_frame(1, 1);
      send_word(1, 8'h20, 0);
      chk("restart_vld", 32'(ov[1]), 1);
      chk("restart_data", 32'(od[1]), 32'h20);
      chk("restart_mis", 32'(em[1]), 0);
      accept(1, "restart");

      // zero-length frame; overrun in DONE; acc_start ignored in DONE
      start_frame(0, 0);
      chk("len0_vld", 32'(ov[0]), 1);
      chk("len0_data", 32'(od[0]), 0);
      send_chunk(0, 8'h55, 1'b1);
      chk("ovr_done", 32'(eo[0]), 1);
      chk("ovr_data", 32'(od[0]), 0);
      start_frame(0, 3);
      chk("done_ign_start", 32'(ov[0]), 1);
      accept(0, "len0");
      pulse_clr(0);
      chk("ovr_clr", 32'(eo[0]), 0);

      // overrun in IDLE
      send_chunk(1, 8'd0, 1'b1);
      chk("ovr_idle", 32'(eo[1]), 1);
      chk("ovr_idle_vld", 32'(ov[1]), 0);
      pulse_clr(1);

      // reset after 2 of 4 words; fresh frame yields only its own sum
      start_frame(2, 4);
      send_word(2, 8'h44, 0);
      send_word(2, 8'h21, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mrst_data", 32'(od[2]), 0);
      chk("mrst_vld", 32'(ov[2]), 0);
      chk("mrst_idle", 32'(idle[2]), 1);
      chk("mrst_mis", 32'(em[2]), 0);
      start_frame(2, 4);
      send_word(2, 8'h11, 0);
      send_word(2, 8'h22, 0);
      send_word(2, 8'h83, 0);
      send_word(2, 8'h7F, 0);
      chk("mrst_vld2", 32'(ov[2]), 1);
      chk("mrst_sum", 32'(od[2]), 32'h35);
      accept(2, "mrst");

      // random frames against an integer-sum reference
      for (int d = 0; d < 3; d++) begin
         for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 6);
            s   = 0;
            start_frame(d, len);
            for (int i = 0; i < len; i++) begin
               w = 8'($urandom_range(0, 255));
               s = s + $signed(w);
               send_word(d, w, 30);
            end
            exp_sum = 24'(s);
            chk($sformatf("rnd_vld_d%0d", d), 32'(ov[d]), 1);
            chk($sformatf("rnd_sum_d%0d", d), 32'(od[d]), 32'(exp_sum));
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
               tick();
               chk($sformatf("rnd_hold_d%0d", d), 32'(od[d]), 32'(exp_sum));
            end
            chk($sformatf("rnd_mis_d%0d", d), 32'(em[d]), 0);
            chk($sformatf("rnd_ovr_d%0d", d), 32'(eo[d]), 0);
            accept(d, "rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
